uart_tx: RTL and testbench

Memory-mapped UART transmitter on the `openmips` data bus, in the same bus slot and with the same bus signals as `data_ram`. The CPU writes bytes into an internal FIFO; a frame FSM serialises them as 8N1 on `txd`. A level interrupt, intended for a free `int_i` bit, flags that transmission has drained. Upper-address decode and `ce_i` gating are done outside; this block decodes `addr_i[3:2]` only.

---
 rtl/uart_tx.sv | 159 +++++++++++++++
 tb/tb_uart_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the openmips data bus.
// CPU writes fill a small FIFO; a frame FSM drains it onto txd and raises int_o when drained.
module uart_tx #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        txd,
    output logic        int_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf, txen, inten;
    logic [15:0]   divisor;
    logic [7:0]    shift, shift_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [15:0]   baud, baud_next;
    logic          full, empty, busy, wr, push, pop, accept;
    logic [1:0]    offset;
    logic          unused;

    assign unused = ^{addr_i[31:4], addr_i[1:0], sel_i[3:1], data_i[31:16]};

    assign offset = addr_i[3:2];
    assign wr     = ce_i & we_i;
    assign full   = (count == CW'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign busy   = (state != IDLE);
    assign push   = wr & (offset == 2'd0) & sel_i[0];
    // A push into a full FIFO still fits when the FSM pops in the same cycle.
    assign accept = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= data_i[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            txen    <= 1'b0;
            inten   <= 1'b0;
            divisor <= DIV_RESET;
            int_o   <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && !accept)
                ovf <= 1'b1;
            else if (wr && offset == 2'd1 && data_i[3])
                ovf <= 1'b0;
            if (wr && offset == 2'd2)
                {inten, txen} <= data_i[1:0];
            if (wr && offset == 2'd3)
                divisor <= (data_i[15:0] == 16'd0) ? 16'd1 : data_i[15:0];
            int_o <= inten & empty & (state == IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= 8'd0;
            bit_idx <= 3'd0;
            baud    <= 16'd0;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_idx <= bit_idx_next;
            baud    <= baud_next;
        end
    end

    // txd is decoded straight from the state so an async reset forces it high at once.
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        baud_next    = baud;
        pop          = 1'b0;
        txd          = 1'b1;
        case (state)
            IDLE: begin
                if (txen && !empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    baud_next  = divisor;
                    state_next = START;
                end
            end
            START: begin
                txd = 1'b0;
                if (baud == 16'd1) begin
                    baud_next    = divisor;
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                end else begin
                    baud_next = baud - 16'd1;
                end
            end
            DATA: begin
                txd = shift[0];
                if (baud == 16'd1) begin
                    baud_next  = divisor;
                    shift_next = shift >> 1;
                    if (bit_idx == 3'd7)
                        state_next = STOP;
                    else
                        bit_idx_next = bit_idx + 3'd1;
                end else begin
                    baud_next = baud - 16'd1;
                end
            end
            STOP: begin
                if (baud == 16'd1)
                    state_next = IDLE;
                else
                    baud_next = baud - 16'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        data_o = 32'd0;
        if (ce_i && !we_i) begin
            case (offset)
                2'd1:    data_o = {23'd0, 5'(count), ovf, busy, empty, full};
                2'd2:    data_o = {30'd0, inten, txen};
                2'd3:    data_o = {16'd0, divisor};
                default: data_o = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a txd frame monitor checks every byte against a scoreboard
// filled at write time; register reads, latency and interrupt timing are asserted inline.
module tb_uart_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [3:0]  sel_i = 4'd0;
    logic [31:0] data_i = 32'd0;
    logic [31:0] data_o;
    logic        txd;
    logic        int_o;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          bench_div = 434;
    int          last_start = -1;
    bit          mon_on = 1'b1;
    bit          check_pitch = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_rx;
    logic [7:0]  mon_exp;
    logic        mon_ok;
    logic        mon_first;
    int          mon_d;
    int          start_cyc;
    logic [31:0] rd;

    uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd434)) dut (
        .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
        .sel_i(sel_i), .data_i(data_i), .data_o(data_o), .txd(txd), .int_o(int_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] off, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        ce_i = 1'b1; we_i = 1'b1; addr_i = {28'd0, off, 2'b00}; data_i = d; sel_i = s;
        @(negedge clk);
        ce_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; data_i = 32'd0; sel_i = 4'd0;
    endtask

    task automatic readReg(input logic [1:0] off, output logic [31:0] d);
        ce_i = 1'b1; we_i = 1'b0; addr_i = {28'd0, off, 2'b00};
        #1;
        d = data_o;
        ce_i = 1'b0; addr_i = 32'd0;
    endtask

    task automatic pushByte(input logic [7:0] b);
        exp_q.push_back(b);
        applyStimulus(2'd0, {24'd0, b}, 4'hF);
    endtask

    // Frame monitor: every bit slot must hold one level for exactly bench_div clocks.
    always begin
        @(negedge clk);
        if (mon_on && !rst && txd === 1'b0) begin
            mon_d = bench_div;
            mon_ok = 1'b1;
            start_cyc = cyc;
            if (check_pitch && last_start >= 0)
                checkOutput("frame_pitch", 32'(start_cyc - last_start), 32'(10 * mon_d + 1));
            last_start = start_cyc;
            for (int s = 0; s < 10; s++) begin
                for (int k = 0; k < mon_d; k++) begin
                    if (s != 0 || k != 0) @(negedge clk);
                    if (k == 0) mon_first = txd;
                    else if (txd !== mon_first) mon_ok = 1'b0;
                end
                if (s == 0 && mon_first !== 1'b0) mon_ok = 1'b0;
                if (s == 9 && mon_first !== 1'b1) mon_ok = 1'b0;
                if (s >= 1 && s <= 8) mon_rx[s-1] = mon_first;
            end
            checkOutput("frame_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                checkOutput("frame_byte", {24'd0, mon_rx}, {24'd0, mon_exp});
            end
            checkOutput("frame_timing", {31'd0, mon_ok}, 32'd1);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_txd", {31'd0, txd}, 32'd1);
        checkOutput("rst_int", {31'd0, int_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        readReg(2'd1, rd); checkOutput("rst_status", rd, 32'h2);
        readReg(2'd3, rd); checkOutput("rst_divisor", rd, 32'd434);
        readReg(2'd2, rd); checkOutput("rst_ctrl", rd, 32'd0);
        readReg(2'd0, rd); checkOutput("txdata_read", rd, 32'd0);

        // Lane select and divisor boundary
        applyStimulus(2'd0, 32'h55, 4'hE);
        readReg(2'd1, rd); checkOutput("sel0_ignored", rd, 32'h2);
        applyStimulus(2'd3, 32'hABCD0000, 4'h0);
        readReg(2'd3, rd); checkOutput("div_zero", rd, 32'd1);
        applyStimulus(2'd3, 32'd4, 4'h1);
        bench_div = 4;
        readReg(2'd3, rd); checkOutput("div_four", rd, 32'd4);

        // Single byte latency and busy duration
        applyStimulus(2'd2, 32'h1, 4'h1);
        pushByte(8'hA5);
        checkOutput("pre_start_txd", {31'd0, txd}, 32'd1);
        @(negedge clk);
        checkOutput("start_latency", {31'd0, txd}, 32'd0);
        repeat (39) @(negedge clk);
        readReg(2'd1, rd); checkOutput("busy_at_40", rd & 32'h4, 32'h4);
        @(negedge clk);
        readReg(2'd1, rd); checkOutput("idle_at_41", rd, 32'h2);
        checkOutput("single_sent", 32'(exp_q.size()), 32'd0);

        // Overflow with transmitter disabled
        applyStimulus(2'd2, 32'h0, 4'h1);
        for (int i = 1; i <= 8; i++) pushByte(8'(i));
        applyStimulus(2'd0, 32'h09, 4'h1);
        readReg(2'd1, rd); checkOutput("ovf_status", rd, 32'h89);
        applyStimulus(2'd1, 32'h8, 4'h1);
        readReg(2'd1, rd); checkOutput("ovf_clear", rd, 32'h81);

        // Drain in order, with pointer wrap from mid-drain pushes
        last_start = -1;
        check_pitch = 1'b1;
        applyStimulus(2'd2, 32'h1, 4'h1);
        repeat (148) @(negedge clk);
        for (int i = 0; i < 4; i++) pushByte(8'h11 + 8'(i));
        readReg(2'd1, rd); checkOutput("refill_status", rd, 32'h85);
        for (int i = 0; i < 700 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("drain_done", 32'(exp_q.size()), 32'd0);
        check_pitch = 1'b0;
        repeat (3) @(negedge clk);
        readReg(2'd1, rd); checkOutput("drain_status", rd, 32'h2);

        // Interrupt timing
        applyStimulus(2'd2, 32'h3, 4'h1);
        repeat (2) @(negedge clk);
        checkOutput("int_idle", {31'd0, int_o}, 32'd1);
        pushByte(8'h3C);
        checkOutput("int_registered", {31'd0, int_o}, 32'd1);
        @(negedge clk);
        checkOutput("int_fall", {31'd0, int_o}, 32'd0);
        repeat (39) @(negedge clk);
        checkOutput("int_frame", {31'd0, int_o}, 32'd0);
        @(negedge clk);
        checkOutput("int_enter_idle", {31'd0, int_o}, 32'd0);
        @(negedge clk);
        checkOutput("int_rise", {31'd0, int_o}, 32'd1);
        pushByte(8'h5A);
        checkOutput("int_hold", {31'd0, int_o}, 32'd1);
        @(negedge clk);
        checkOutput("int_drop", {31'd0, int_o}, 32'd0);
        repeat (45) @(negedge clk);
        checkOutput("int_frames_sent", 32'(exp_q.size()), 32'd0);

        // Disable mid-frame
        applyStimulus(2'd2, 32'h0, 4'h1);
        pushByte(8'h77);
        pushByte(8'h88);
        applyStimulus(2'd2, 32'h1, 4'h1);
        repeat (10) @(negedge clk);
        applyStimulus(2'd2, 32'h0, 4'h1);
        repeat (60) @(negedge clk);
        checkOutput("dis_txd", {31'd0, txd}, 32'd1);
        readReg(2'd1, rd); checkOutput("dis_status", rd, 32'h10);
        checkOutput("dis_pending", 32'(exp_q.size()), 32'd1);
        applyStimulus(2'd2, 32'h1, 4'h1);
        repeat (50) @(negedge clk);
        checkOutput("reenable_sent", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-frame
        mon_on = 1'b0;
        applyStimulus(2'd0, 32'hF0, 4'h1);
        applyStimulus(2'd0, 32'hF1, 4'h1);
        repeat (10) @(negedge clk);
        checkOutput("pre_rst_txd", {31'd0, txd}, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_txd", {31'd0, txd}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        readReg(2'd1, rd); checkOutput("rst_fifo_flush", rd, 32'h2);
        readReg(2'd3, rd); checkOutput("rst_div_again", rd, 32'd434);
        readReg(2'd2, rd); checkOutput("rst_ctrl_again", rd, 32'd0);
        applyStimulus(2'd2, 32'h2, 4'h1);
        repeat (2) @(negedge clk);
        checkOutput("int_inten_only", {31'd0, int_o}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_int", {31'd0, int_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
